joystick_reader: RTL and testbench
==================================

// Module: joystick_reader
// PURPOSE
//  SPI master polling the PmodJSTK; decodes X axis and button bits into the 4-bit
//  Joystick_data direction code and Fire strobe consumed by the player and bullet logic.
//  Sits between the board pins and the player-position stage; sole source of user input.
// PARAMETERS
//  CLK_DIV      50      Clk cycles per SCLK half-period (SCLK = Clk/(2*CLK_DIV))
//  POLL_CYCLES  500000  Clk cycles from one transaction start to the next (>= transaction length)
//  SS_SETUP     1000    Clk cycles SS_n low before first SCLK edge, and min gap between bytes
//  X_LOW        10'd384 X strictly below this -> LEFT
//  X_HIGH       10'd640 X strictly above this -> RIGHT
// PORTS
//  Clk            in   1   system clock
//  Reset          in   1   asynchronous, active-low reset
//  MISO           in   1   serial data from joystick
//  SS_n           out  1   slave select, active low
//  SCLK           out  1   SPI clock, idle low (mode 0)
//  MOSI           out  1   tied 0 (LED command bits unused)
//  Joystick_data  out  4   direction: 4'd3 LEFT, 4'd5 CENTER, 4'd7 RIGHT; no other values
//  Fire           out  1   one-Clk pulse on button-0 rising edge (0->1 between transactions)
//  Sample_valid   out  1   one-Clk pulse when Joystick_data/Fire updated from a new transaction
// BEHAVIOUR
//  - Reset low: SS_n=1, SCLK=0, MOSI=0, Joystick_data=5, Fire=0, Sample_valid=0,
//    poll counter=0, prev button=0, FSM=IDLE. Reset mid-transaction aborts immediately;
//    partial data discarded; first transaction starts POLL_CYCLES after release.
//  - FSM: IDLE -(poll counter hits POLL_CYCLES-1, counter wraps to 0)-> SETUP (SS_n=0)
//    -(SS_SETUP cycles)-> SHIFT -(8 bits done, bytes<5)-> GAP -(SS_SETUP cycles)-> SHIFT;
//    SHIFT -(8 bits done, byte 5)-> DONE (SS_n=1) -> IDLE next cycle.
//  - Poll counter free-runs in all states; transaction must fit within POLL_CYCLES.
//  - SHIFT: mode 0, MSB first; MISO sampled on the Clk where SCLK rises; SCLK returns
//    low after CLK_DIV more cycles; SCLK held low in SETUP/GAP/DONE/IDLE.
//  - Frame: byte0 X[7:0], byte1 {6'b0,X[9:8]}, byte2 Y[7:0], byte3 {6'b0,Y[9:8]},
//    byte4 buttons (bit0 = fire). Y captured but unused.
//  - DONE cycle: decode X (10-bit unsigned): X<X_LOW->3, X>X_HIGH->7, else 5
//    (X==X_LOW or X==X_HIGH -> 5). Outputs register on the following Clk together
//    with Sample_valid=1; Fire=1 in the same cycle iff button0=1 and prev button=0;
//    prev button <= button0.
//  - Joystick_data holds between updates; never glitches mid-transaction.
// CONFIGURATION
//  JOYSTICK_DEBOUNCE_EN defined: direction applied to Joystick_data only after two
//  consecutive transactions decode the same code; Sample_valid still pulses each
//  transaction; Fire unaffected. Undefined: each transaction's decode applied directly.
// STRUCTURE
//  joystick_pkg: direction codes (DIR_LEFT=3, DIR_CENTER=5, DIR_RIGHT=7), FSM state
//  enum (IDLE, SETUP, SHIFT, GAP, DONE), frame byte count (5).
//  Sub-module spi_byte_rx: SCLK generation + 8-bit shift register for one byte,
//  start/done handshake with the FSM; top holds FSM, frame assembly, decode, debounce.
// TESTING (CLK_DIV=2, POLL_CYCLES=400, SS_SETUP=4, bench SPI slave model)
//  - Reset asserted -> SS_n=1, SCLK=0, Joystick_data=5, Fire=0; released -> SS_n falls at cycle 400.
//  - Slave sends X=10'd100, btn=0 -> exactly 40 SCLK rising edges, Joystick_data=3, Sample_valid 1 cycle.
//  - X=10'd900 -> 7; X=10'd640 -> 5; X=10'd384 -> 5; X=10'd383 -> 3.
//  - btn 0,1,1,0,1 over five transactions -> Fire pulses after 2nd and 5th only.
//  - Reset low during byte 2 -> SS_n=1 immediately, outputs at reset values, no Sample_valid.
//  - DEBOUNCE_EN: X codes 7,5,7,7 -> Joystick_data stays 5 until after the 4th transaction, then 7.

Source files
------------

// File: rtl/joystick_pkg.sv
// ----------------------------------------------------------------------------
// joystick_pkg: direction codes, FSM states and helpers for joystick_reader.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package joystick_pkg;

  localparam logic [3:0] DIR_LEFT    = 4'd3;
  localparam logic [3:0] DIR_CENTER  = 4'd5;
  localparam logic [3:0] DIR_RIGHT   = 4'd7;
  localparam int         FRAME_BYTES = 5;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_SHIFT = 3'd2,
    ST_GAP   = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Boundary values themselves decode as CENTER.
  function automatic logic [3:0] decode_x(input logic [9:0] x,
                                          input logic [9:0] lo,
                                          input logic [9:0] hi);
    if (x < lo)      return DIR_LEFT;
    else if (x > hi) return DIR_RIGHT;
    else             return DIR_CENTER;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_byte_rx.sv
// ----------------------------------------------------------------------------
// spi_byte_rx: mode-0 SCLK generator and MSB-first 8-bit receiver for one byte.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module spi_byte_rx
  import joystick_pkg::*;
#(
  parameter int CLK_DIV = 50
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_start,
  input  logic       i_miso,
  output logic       o_sclk,
  output logic       o_done,
  output logic [7:0] o_data
);

  localparam int            DW       = cnt_width(CLK_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  logic          r_busy;
  logic [DW-1:0] r_div;
  logic [2:0]    r_bit;
  logic          r_sclk;
  logic          r_done;
  logic [7:0]    r_shift;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy  <= 1'b0;
      r_div   <= '0;
      r_bit   <= 3'd0;
      r_sclk  <= 1'b0;
      r_done  <= 1'b0;
      r_shift <= 8'd0;
    end else begin
      r_done <= 1'b0;
      if (i_start) begin
        r_busy <= 1'b1;
        r_div  <= '0;
        r_bit  <= 3'd0;
        r_sclk <= 1'b0;
      end else if (r_busy) begin
        if (r_div == DIV_LAST) begin
          r_div <= '0;
          if (!r_sclk) begin
            // MISO is captured on the same Clk edge that raises SCLK.
            r_sclk  <= 1'b1;
            r_shift <= {r_shift[6:0], i_miso};
          end else begin
            r_sclk <= 1'b0;
            if (r_bit == 3'd7) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end else begin
              r_bit <= r_bit + 3'd1;
            end
          end
        end else begin
          r_div <= r_div + 1'b1;
        end
      end
    end
  end

  assign o_sclk = r_sclk;
  assign o_done = r_done;
  assign o_data = r_shift;

endmodule

`default_nettype wire

// File: rtl/joystick_reader.sv
// ----------------------------------------------------------------------------
// joystick_reader: PmodJSTK SPI poller producing direction code and Fire strobe.
// Optional build macro JOYSTICK_DEBOUNCE_EN. Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module joystick_reader
  import joystick_pkg::*;
#(
  parameter int         CLK_DIV     = 50,
  parameter int         POLL_CYCLES = 500000,
  parameter int         SS_SETUP    = 1000,
  parameter logic [9:0] X_LOW       = 10'd384,
  parameter logic [9:0] X_HIGH      = 10'd640
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       MISO,
  output logic       SS_n,
  output logic       SCLK,
  output logic       MOSI,
  output logic [3:0] Joystick_data,
  output logic       Fire,
  output logic       Sample_valid
);

  localparam int            PW        = cnt_width(POLL_CYCLES);
  localparam int            SW        = cnt_width(SS_SETUP);
  localparam logic [PW-1:0] POLL_LAST = PW'(POLL_CYCLES - 1);
  localparam logic [SW-1:0] WAIT_LAST = SW'(SS_SETUP - 1);
  localparam logic [2:0]    BYTE_LAST = 3'(FRAME_BYTES - 1);

  state_t        r_state;
  state_t        w_next;
  logic [PW-1:0] r_poll;
  logic [SW-1:0] r_wait;
  logic [2:0]    r_byte;
  logic [9:0]    r_x;
  logic          r_btn;
  logic          r_prev_btn;
  logic [3:0]    r_dir;
  logic          r_fire;
  logic          r_valid;
  logic          w_start;
  logic          w_rx_done;
  logic [7:0]    w_rx_data;
  logic          w_poll_wrap;
  logic          w_wait_done;
  logic [3:0]    w_code;
  logic          w_apply;

  spi_byte_rx #(
    .CLK_DIV (CLK_DIV)
  ) u_rx (
    .i_clk   (Clk),
    .i_rst_n (Reset),
    .i_start (w_start),
    .i_miso  (MISO),
    .o_sclk  (SCLK),
    .o_done  (w_rx_done),
    .o_data  (w_rx_data)
  );

  assign w_poll_wrap = (r_poll == POLL_LAST);
  assign w_wait_done = (r_wait == WAIT_LAST);

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state <= ST_IDLE;
      r_poll  <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      r_poll  <= w_poll_wrap ? '0 : r_poll + 1'b1;
      r_wait  <= (w_next == r_state && (r_state == ST_SETUP || r_state == ST_GAP))
                 ? r_wait + 1'b1 : '0;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    case (r_state)
      ST_IDLE:  if (w_poll_wrap) w_next = ST_SETUP;
      ST_SETUP,
      ST_GAP: begin
        if (w_wait_done) begin
          w_next  = ST_SHIFT;
          w_start = 1'b1;
        end
      end
      ST_SHIFT: if (w_rx_done) w_next = (r_byte == BYTE_LAST) ? ST_DONE : ST_GAP;
      ST_DONE:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Y bytes are clocked in but not retained; only X and buttons drive outputs.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_byte <= 3'd0;
      r_x    <= 10'd0;
      r_btn  <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_byte <= 3'd0;
    end else if (r_state == ST_SHIFT && w_rx_done) begin
      r_byte <= r_byte + 3'd1;
      case (r_byte)
        3'd0:    r_x[7:0] <= w_rx_data;
        3'd1:    r_x[9:8] <= w_rx_data[1:0];
        3'd4:    r_btn    <= w_rx_data[0];
        default: ;
      endcase
    end
  end

  assign w_code = decode_x(r_x, X_LOW, X_HIGH);

`ifdef JOYSTICK_DEBOUNCE_EN
  logic [3:0] r_last_code;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset)                  r_last_code <= DIR_CENTER;
    else if (r_state == ST_DONE) r_last_code <= w_code;
  end

  assign w_apply = (w_code == r_last_code);
`else
  assign w_apply = 1'b1;
`endif

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_dir      <= DIR_CENTER;
      r_fire     <= 1'b0;
      r_valid    <= 1'b0;
      r_prev_btn <= 1'b0;
    end else begin
      r_valid <= (r_state == ST_DONE);
      r_fire  <= (r_state == ST_DONE) && r_btn && !r_prev_btn;
      if (r_state == ST_DONE) begin
        r_prev_btn <= r_btn;
        if (w_apply) r_dir <= w_code;
      end
    end
  end

  assign SS_n          = !(r_state == ST_SETUP || r_state == ST_SHIFT || r_state == ST_GAP);
  assign MOSI          = 1'b0;
  assign Joystick_data = r_dir;
  assign Fire          = r_fire;
  assign Sample_valid  = r_valid;

endmodule

`default_nettype wire

// File: tb/tb_joystick_reader.sv
// ----------------------------------------------------------------------------
// tb_joystick_reader: SPI slave model plus scoreboard of expected decode/Fire.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_joystick_reader;

  localparam int CLK_DIV  = 2;
  localparam int POLL     = 400;
  localparam int SS_SETUP = 4;

  logic       Clk = 1'b0;
  logic       Reset = 1'b0;
  logic       MISO;
  logic       SS_n;
  logic       SCLK;
  logic       MOSI;
  logic [3:0] Joystick_data;
  logic       Fire;
  logic       Sample_valid;

  joystick_reader #(
    .CLK_DIV     (CLK_DIV),
    .POLL_CYCLES (POLL),
    .SS_SETUP    (SS_SETUP),
    .X_LOW       (10'd384),
    .X_HIGH      (10'd640)
  ) dut (
    .Clk           (Clk),
    .Reset         (Reset),
    .MISO          (MISO),
    .SS_n          (SS_n),
    .SCLK          (SCLK),
    .MOSI          (MOSI),
    .Joystick_data (Joystick_data),
    .Fire          (Fire),
    .Sample_valid  (Sample_valid)
  );

  always #5 Clk = ~Clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [39:0] frame   = 40'd0;
  int          bit_idx = 0;
  int          rises   = 0;

  typedef struct packed {
    logic [3:0] dir;
    logic       fire;
  } exp_t;

  exp_t       sb_q[$];
  logic [3:0] m_dir    = 4'd5;
  logic [3:0] m_last   = 4'd5;
  logic       m_prev   = 1'b0;

  // Slave: bit 0 presented on SS_n fall, next bit after each SCLK rise.
  always @(negedge SS_n or posedge SCLK) begin
    if (SCLK === 1'b1) begin
      bit_idx = bit_idx + 1;
      rises   = rises + 1;
    end else begin
      bit_idx = 0;
      rises   = 0;
    end
  end

  assign MISO = (bit_idx < 40) ? frame[39 - bit_idx] : 1'b0;

  function automatic logic [3:0] model_code(input logic [9:0] x);
    if (x < 10'd384)      return 4'd3;
    else if (x > 10'd640) return 4'd7;
    else                  return 4'd5;
  endfunction

  task automatic load_frame(input logic [9:0] x, input logic b);
    logic [9:0] y;
    y     = 10'(x ^ 10'h2A5);
    frame = {x[7:0], 6'b0, x[9:8], y[7:0], 6'b0, y[9:8], 7'b0, b};
  endtask

  task automatic model_reset();
    m_dir  = 4'd5;
    m_last = 4'd5;
    m_prev = 1'b0;
  endtask

  task automatic run_txn(input logic [9:0] x, input logic b, input string name);
    logic [3:0] code;
    logic [3:0] held;
    logic       f;
    exp_t       e;
    bit         seen;
    bit         glitch;
    load_frame(x, b);
    held = m_dir;
    code = model_code(x);
`ifdef JOYSTICK_DEBOUNCE_EN
    if (code == m_last) m_dir = code;
    m_last = code;
`else
    m_dir = code;
`endif
    f      = b && !m_prev;
    m_prev = b;
    sb_q.push_back({m_dir, f});
    seen   = 1'b0;
    glitch = 1'b0;
    for (int n = 0; n < 2 * POLL && !seen; n++) begin
      @(negedge Clk);
      if (Sample_valid === 1'b1) seen = 1'b1;
      else if (Joystick_data !== held || Fire !== 1'b0) glitch = 1'b1;
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL %s timeout: Sample_valid never seen, required 1", name);
      void'(sb_q.pop_front());
      return;
    end
    e = sb_q.pop_front();
    tests_run++;
    if (Joystick_data !== e.dir) begin
      tests_failed++;
      $display("FAIL %s dir: got %0d, expected %0d", name, Joystick_data, e.dir);
    end
    tests_run++;
    if (Fire !== e.fire) begin
      tests_failed++;
      $display("FAIL %s fire: got %b, expected %b", name, Fire, e.fire);
    end
    tests_run++;
    if (rises !== 40) begin
      tests_failed++;
      $display("FAIL %s sclk_rises: got %0d, expected 40", name, rises);
    end
    tests_run++;
    if (glitch) begin
      tests_failed++;
      $display("FAIL %s hold: outputs changed mid-transaction, expected %0d held", name, held);
    end
    @(negedge Clk);
    tests_run++;
    if (Sample_valid !== 1'b0 || Fire !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s pulse_width: valid=%b fire=%b, expected 0 0", name, Sample_valid, Fire);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    tests_run++;
    if (SS_n !== 1'b1 || SCLK !== 1'b0 || MOSI !== 1'b0 || Joystick_data !== 4'd5 ||
        Fire !== 1'b0 || Sample_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL %s: ss_n=%b sclk=%b mosi=%b dir=%0d fire=%b valid=%b, expected 1 0 0 5 0 0",
               name, SS_n, SCLK, MOSI, Joystick_data, Fire, Sample_valid);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge Clk);
    check_reset_outputs("reset_values");
    load_frame(10'd100, 1'b0);
    Reset = 1'b1;
    for (int n = 1; n <= POLL; n++) begin
      @(posedge Clk);
      #1;
      if (n == POLL - 1) begin
        tests_run++;
        if (SS_n !== 1'b1) begin
          tests_failed++;
          $display("FAIL ss_early: SS_n=%b at cycle %0d, expected 1", SS_n, n);
        end
      end
    end
    tests_run++;
    if (SS_n !== 1'b0) begin
      tests_failed++;
      $display("FAIL ss_start: SS_n=%b at cycle %0d, expected 0", SS_n, POLL);
    end
  endtask

  task automatic test_decode();
    run_txn(10'd100, 1'b0, "x100");
    run_txn(10'd900, 1'b0, "x900");
    run_txn(10'd640, 1'b0, "x640");
    run_txn(10'd384, 1'b0, "x384");
    run_txn(10'd383, 1'b0, "x383");
    run_txn(10'd641, 1'b0, "x641");
  endtask

  task automatic test_fire();
    logic [4:0] btns;
    btns = 5'b10110;
    for (int i = 0; i < 5; i++) run_txn(10'd512, btns[i], $sformatf("fire%0d", i));
  endtask

  task automatic test_back_to_back();
    run_txn(10'd900, 1'b0, "deb0");
    run_txn(10'd512, 1'b0, "deb1");
    run_txn(10'd900, 1'b0, "deb2");
    run_txn(10'd900, 1'b0, "deb3");
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit bad_valid;
    load_frame(10'd900, 1'b1);
    ok = 1'b0;
    for (int n = 0; n < 2 * POLL && !ok; n++) begin
      @(negedge Clk);
      if (SS_n === 1'b0 && rises >= 17) ok = 1'b1;
    end
    tests_run++;
    if (!ok) begin
      tests_failed++;
      $display("FAIL mid_reach_byte2: got rises=%0d, expected >= 17", rises);
    end
    Reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset_values");
    model_reset();
    bad_valid = 1'b0;
    repeat (10) begin
      @(negedge Clk);
      if (Sample_valid !== 1'b0 || SS_n !== 1'b1) bad_valid = 1'b1;
    end
    tests_run++;
    if (bad_valid) begin
      tests_failed++;
      $display("FAIL mid_abort: valid or SS_n active during reset, expected 0 and 1");
    end
    Reset = 1'b1;
    run_txn(10'd200, 1'b1, "after_reset");
  endtask

  initial begin
    test_reset();
    test_decode();
    test_fire();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

`default_nettype wire
